// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: sequencer state encoding and the
// default address/instruction widths, reset PC and fetch timeout.
package fetch_sequencer_pkg;

  localparam int unsigned DefaultAddrW        = 16;
  localparam int unsigned DefaultInstrW       = 16;
  localparam int unsigned DefaultResetPc      = 0;
  localparam int unsigned DefaultFetchTimeout = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StIssue = 2'd2,
    StHalt  = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and decode.
//   imem_*       : fetch request/acknowledge to instruction memory
//   instr_*/pc_o : instruction presented to decode (valid/ready)
//   branch_i, target_i, halt_i : decode verdict, sampled at the decode handshake
//   halted_o     : sequencer stopped
//   fault_o      : fetch timeout, present only when FETCH_TIMEOUT_EN is defined
// Modport master is the sequencer side, slave is the memory/decode side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned INSTR_W = DefaultInstrW
);

  logic               imem_req_o;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic               imem_ack_i;
  logic [INSTR_W-1:0] imem_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic [ADDR_W-1:0]  pc_o;
  logic               branch_i;
  logic [ADDR_W-1:0]  target_i;
  logic               halt_i;
  logic               halted_o;
`ifdef FETCH_TIMEOUT_EN
  logic               fault_o;
`endif

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_data_i,
    output instr_o, instr_valid_o, pc_o,
    input  instr_ready_i, branch_i, target_i, halt_i,
    output halted_o
`ifdef FETCH_TIMEOUT_EN
    , output fault_o
`endif
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_data_i,
    input  instr_o, instr_valid_o, pc_o,
    output instr_ready_i, branch_i, target_i, halt_i,
    input  halted_o
`ifdef FETCH_TIMEOUT_EN
    , input fault_o
`endif
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Fetch timeout watchdog, built only when FETCH_TIMEOUT_EN is defined.
// Counts request cycles that pass without an acknowledge and flags expiry in
// the TIMEOUT-th such cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : entering a new request (clears the count)
//   active_i     : a request is outstanding this cycle
//   ack_i        : memory acknowledge
//   expired_o    : this request cycle is the last one allowed
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  // cnt_q holds the number of ack-less request cycles already completed, so
  // the count reaches TIMEOUT during the cycle in which cnt_q == TIMEOUT-1.
  assign expired_o = active_i && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      cnt_q <= '0;
    end else if (active_i && !ack_i && !expired_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer. Fetches from instruction
// memory over req/ack, presents each word to decode over valid/ready, and at
// the decode handshake either redirects to the branch target, falls through
// to PC+1, or stops on HALT.
//   clk_i : clock (rising edge)
//   rst_i : synchronous active-high reset
//   bus   : fetch_sequencer_if.master (memory, decode and status signals)
// Optional build macro FETCH_TIMEOUT_EN adds a fetch watchdog: a request left
// unacknowledged for FETCH_TIMEOUT cycles raises the sticky fault_o and halts.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefaultAddrW,
  parameter int unsigned       INSTR_W  = DefaultInstrW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefaultResetPc)
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned       FETCH_TIMEOUT = DefaultFetchTimeout
`endif
) (
  input logic               clk_i,
  input logic               rst_i,
  fetch_sequencer_if.master bus
);

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_next_q;
  logic [ADDR_W-1:0]  pc_cur_q;
  logic [INSTR_W-1:0] instr_q;
  logic               expired;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q;
  logic wd_start;
  logic wd_active;

  // A request starts on leaving IDLE or after an accepted decode handshake.
  assign wd_start  = (state_q == StIdle) || ((state_q == StIssue) && bus.instr_ready_i);
  assign wd_active = (state_q == StReq);

  fetch_watchdog #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (wd_start),
    .active_i  (wd_active),
    .ack_i     (bus.imem_ack_i),
    .expired_o (expired)
  );

  assign bus.fault_o = fault_q;
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_next_q <= RESET_PC;
      pc_cur_q  <= RESET_PC;
      instr_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          // An ack arriving in the expiry cycle is dropped.
          if (expired) begin
            state_q <= StHalt;
`ifdef FETCH_TIMEOUT_EN
            fault_q <= 1'b1;
`endif
          end else if (bus.imem_ack_i) begin
            instr_q   <= bus.imem_data_i;
            pc_cur_q  <= pc_next_q;
            pc_next_q <= pc_next_q + ADDR_W'(1);
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (bus.instr_ready_i) begin
            // Target still loads on HALT so imem_addr_o shows where it would go.
            if (bus.branch_i) pc_next_q <= bus.target_i;
            state_q <= bus.halt_i ? StHalt : StReq;
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.imem_req_o    = (state_q == StReq);
  assign bus.imem_addr_o   = pc_next_q;
  assign bus.instr_valid_o = (state_q == StIssue);
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_cur_q;
  assign bus.halted_o      = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// phase, all checked every cycle against a transaction-level model.
module tb_fetch_sequencer;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 16;
  localparam logic [AW-1:0] RST_PC = 16'h0000;
`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TMO = 15;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_sequencer #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (RST_PC)
`ifdef FETCH_TIMEOUT_EN
    ,
    .FETCH_TIMEOUT (TMO)
`endif
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [IW-1:0] mem [0:65535];

  // Memory responder configuration.
  int rsp_min = 0;
  int rsp_max = 0;
  bit rsp_never = 1'b0;
  bit rsp_spur = 1'b0;

  // Observed fetch addresses and decode handshakes.
  logic [AW-1:0] fetch_log[$];
  logic [AW-1:0] hs_pc_log[$];
  logic [IW-1:0] hs_instr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] qat(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hDEAD0000;
  endfunction

  // Instruction memory: random extra delay per request, optional stray acks.
  initial begin : responder
    int wcnt;
    int del;
    wcnt = 0;
    del = 0;
    bus.imem_ack_i = 1'b0;
    bus.imem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_ack_i = 1'b0;
      bus.imem_data_i = IW'($urandom);
      if (bus.imem_req_o === 1'b1) begin
        if (wcnt == 0) del = $urandom_range(rsp_max, rsp_min);
        if (!rsp_never && wcnt == del) begin
          bus.imem_ack_i = 1'b1;
          bus.imem_data_i = mem[bus.imem_addr_o];
        end
        wcnt++;
      end else begin
        wcnt = 0;
        if (rsp_spur && $urandom_range(3, 0) == 0) bus.imem_ack_i = 1'b1;
      end
    end
  end

  // Reference model: what the sequencer is doing this cycle.
  bit            checking = 1'b0;
  bit            m_idle, m_fetch, m_issue, m_halt;
  logic [AW-1:0] m_pc_next, m_pc;
  logic [IW-1:0] m_instr;
  int            m_req_cycles;
`ifdef FETCH_TIMEOUT_EN
  bit            m_fault;
`endif

  initial begin : compare
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("req", 32'(bus.imem_req_o), 32'(m_fetch));
        chk("valid", 32'(bus.instr_valid_o), 32'(m_issue));
        chk("halted", 32'(bus.halted_o), 32'(m_halt));
        chk("addr", 32'(bus.imem_addr_o), 32'(m_pc_next));
        chk("pc", 32'(bus.pc_o), 32'(m_pc));
        chk("instr", 32'(bus.instr_o), 32'(m_instr));
        chk("req_and_valid", 32'(bus.imem_req_o & bus.instr_valid_o), 0);
`ifdef FETCH_TIMEOUT_EN
        chk("fault", 32'(bus.fault_o), 32'(m_fault));
`endif
        if (m_fetch && bus.imem_ack_i) fetch_log.push_back(bus.imem_addr_o);
        if (m_issue && bus.instr_ready_i) begin
          hs_pc_log.push_back(bus.pc_o);
          hs_instr_log.push_back(bus.instr_o);
        end
      end
      // Advance to what must hold after the coming edge.
      if (rst) begin
        m_idle = 1'b1; m_fetch = 1'b0; m_issue = 1'b0; m_halt = 1'b0;
        m_pc_next = RST_PC; m_pc = RST_PC; m_instr = '0; m_req_cycles = 0;
`ifdef FETCH_TIMEOUT_EN
        m_fault = 1'b0;
`endif
        checking = 1'b1;
      end else if (m_idle) begin
        m_idle = 1'b0;
        m_fetch = 1'b1;
        m_req_cycles = 0;
      end else if (m_fetch) begin
        m_req_cycles++;
`ifdef FETCH_TIMEOUT_EN
        if (m_req_cycles == TMO) begin
          m_fetch = 1'b0; m_halt = 1'b1; m_fault = 1'b1;
        end else
`endif
        if (bus.imem_ack_i) begin
          m_pc = m_pc_next;
          m_instr = mem[m_pc_next];
          m_pc_next = 16'(m_pc_next + 16'd1);
          m_fetch = 1'b0;
          m_issue = 1'b1;
        end
      end else if (m_issue && bus.instr_ready_i) begin
        if (bus.branch_i) m_pc_next = bus.target_i;
        m_issue = 1'b0;
        if (bus.halt_i) m_halt = 1'b1;
        else begin
          m_fetch = 1'b1;
          m_req_cycles = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    fetch_log.delete();
    hs_pc_log.delete();
    hs_instr_log.delete();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (bus.instr_valid_o !== 1'b1 && k < budget) begin
      cyc();
      k++;
    end
    chk(name, 32'(bus.instr_valid_o), 1);
  endtask

  task automatic wait_hs(input string name, input int n, input int budget);
    int k = 0;
    while (hs_pc_log.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk(name, hs_pc_log.size(), n);
  endtask

  initial begin : global_bound
    #2000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    logic [AW-1:0] p;
    logic [IW-1:0] ins;
    int cnt;
    int k;
    int hcount;

    bus.instr_ready_i = 1'b0;
    bus.branch_i = 1'b0;
    bus.target_i = '0;
    bus.halt_i = 1'b0;
    for (int i = 0; i < 65536; i++) mem[16'(i)] = IW'($urandom);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[16'h0040] = 16'h4040;
    mem[16'hFFFF] = 16'hBEEF;

    // Reset state.
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_req", 32'(bus.imem_req_o), 0);
    chk("rst_valid", 32'(bus.instr_valid_o), 0);
    chk("rst_halted", 32'(bus.halted_o), 0);
    chk("rst_pc", 32'(bus.pc_o), 0);
    chk("rst_addr", 32'(bus.imem_addr_o), 0);
    chk("rst_instr", 32'(bus.instr_o), 0);

    // Straight-line fetch with immediate acks.
    clear_logs();
    bus.instr_ready_i = 1'b1;
    wait_hs("seq_hs_count", 3, 40);
    chk("seq_fetch0", qat(fetch_log, 0), 0);
    chk("seq_fetch1", qat(fetch_log, 1), 1);
    chk("seq_fetch2", qat(fetch_log, 2), 2);
    chk("seq_instr0", qat(hs_instr_log, 0), 'h1111);
    chk("seq_pc0", qat(hs_pc_log, 0), 0);
    chk("seq_instr1", qat(hs_instr_log, 1), 'h2222);
    chk("seq_pc1", qat(hs_pc_log, 1), 1);
    chk("seq_instr2", qat(hs_instr_log, 2), 'h3333);
    chk("seq_pc2", qat(hs_pc_log, 2), 2);

    // Branch taken at pc 1.
    do_reset(1);
    clear_logs();
    k = 0;
    while (hs_pc_log.size() < 3 && k < 40) begin
      bus.branch_i = bus.instr_valid_o && (bus.pc_o == 16'd1);
      bus.target_i = 16'h0040;
      cyc();
      k++;
    end
    bus.branch_i = 1'b0;
    chk("br_hs_count", hs_pc_log.size(), 3);
    chk("br_fetch2", qat(fetch_log, 2), 'h40);
    chk("br_pc2", qat(hs_pc_log, 2), 'h40);
    chk("br_instr2", qat(hs_instr_log, 2), 'h4040);

    // Back-pressure with branch_i toggling before the handshake.
    bus.instr_ready_i = 1'b0;
    wait_valid("bp_wait_valid", 20);
    p = bus.pc_o;
    ins = bus.instr_o;
    repeat (5) begin
      bus.branch_i = 1'($urandom);
      bus.target_i = 16'($urandom);
      cyc();
      chk("bp_pc_stable", 32'(bus.pc_o), 32'(p));
      chk("bp_instr_stable", 32'(bus.instr_o), 32'(ins));
      chk("bp_no_req", 32'(bus.imem_req_o), 0);
    end
    bus.branch_i = 1'b0;
    bus.instr_ready_i = 1'b1;
    cyc();
    bus.instr_ready_i = 1'b0;
    chk("bp_next_req", 32'(bus.imem_req_o), 1);
    chk("bp_next_addr", 32'(bus.imem_addr_o), 32'(16'(p + 16'd1)));

    // Wrap and stall: branch to 0xFFFF, ack three cycles late.
    rsp_min = 3;
    rsp_max = 3;
    wait_valid("wr_wait_valid", 30);
    bus.instr_ready_i = 1'b1;
    bus.branch_i = 1'b1;
    bus.target_i = 16'hFFFF;
    cyc();
    bus.instr_ready_i = 1'b0;
    bus.branch_i = 1'b0;
    cnt = 0;
    k = 0;
    while (bus.instr_valid_o !== 1'b1 && k < 30) begin
      if (bus.imem_req_o && bus.imem_addr_o == 16'hFFFF) cnt++;
      cyc();
      k++;
    end
    chk("wr_stall_cycles", cnt, 4);
    chk("wr_pc", 32'(bus.pc_o), 'hFFFF);
    chk("wr_instr", 32'(bus.instr_o), 'hBEEF);
    bus.instr_ready_i = 1'b1;
    cyc();
    bus.instr_ready_i = 1'b0;
    chk("wr_next_req", 32'(bus.imem_req_o), 1);
    chk("wr_next_addr", 32'(bus.imem_addr_o), 0);
    rsp_min = 0;
    rsp_max = 0;

    // Halt and branch at the same handshake, then restart.
    wait_valid("hb_wait_valid", 30);
    bus.instr_ready_i = 1'b1;
    bus.halt_i = 1'b1;
    bus.branch_i = 1'b1;
    bus.target_i = 16'h1234;
    cyc();
    bus.halt_i = 1'b0;
    bus.branch_i = 1'b0;
    chk("hb_halted", 32'(bus.halted_o), 1);
    chk("hb_addr_target", 32'(bus.imem_addr_o), 'h1234);
    repeat (3) begin
      cyc();
      chk("hb_no_req", 32'(bus.imem_req_o), 0);
      chk("hb_still_halted", 32'(bus.halted_o), 1);
    end
    do_reset(1);
    chk("hb_rst_halted", 32'(bus.halted_o), 0);
    chk("hb_rst_idle", 32'(bus.imem_req_o), 0);
    cyc();
    chk("hb_restart_req", 32'(bus.imem_req_o), 1);
    chk("hb_restart_addr", 32'(bus.imem_addr_o), 32'(RST_PC));

    // Random traffic, stray acks, halts and occasional resets.
    rsp_min = 0;
    rsp_max = 4;
    rsp_spur = 1'b1;
    hcount = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.instr_ready_i = ($urandom_range(2, 0) != 0);
      bus.branch_i = ($urandom_range(3, 0) == 0);
      bus.target_i = 16'($urandom);
      bus.halt_i = ($urandom_range(31, 0) == 0);
      if (bus.halted_o) hcount++;
      rst = (hcount >= 2) || ($urandom_range(299, 0) == 0);
      if (rst) hcount = 0;
      cyc();
    end
    rst = 1'b0;
    rsp_spur = 1'b0;
    bus.halt_i = 1'b0;
    bus.branch_i = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // Never acknowledged: fault after FETCH_TIMEOUT request cycles.
    rsp_never = 1'b1;
    bus.instr_ready_i = 1'b1;
    do_reset(1);
    cnt = 0;
    k = 0;
    while (bus.halted_o !== 1'b1 && k < 40) begin
      if (bus.imem_req_o) cnt++;
      cyc();
      k++;
    end
    chk("to_req_cycles", cnt, TMO);
    chk("to_fault", 32'(bus.fault_o), 1);
    chk("to_halted", 32'(bus.halted_o), 1);
    do_reset(1);
    chk("to_rst_fault", 32'(bus.fault_o), 0);
    chk("to_rst_halted", 32'(bus.halted_o), 0);
    chk("to_rst_idle", 32'(bus.imem_req_o), 0);
    repeat (7) cyc();
    chk("to_mid_req", 32'(bus.imem_req_o), 1);
    do_reset(1);
    chk("to_mid_rst_idle", 32'(bus.imem_req_o), 0);
    chk("to_mid_rst_fault", 32'(bus.fault_o), 0);
    cyc();
    chk("to_mid_restart", 32'(bus.imem_req_o), 1);
    rsp_never = 1'b0;
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
